decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 52 +++++
 rtl/decode_stage_fwd_sel.sv | 34 +++
 rtl/decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage: icodes, stat codes, register IDs, widths.
// The D-register layout and its bubble value live here so every file agrees on them.
package decode_stage_pkg;

    localparam int NIBBLE = 4;
    localparam int WORD   = 32;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam int         REGNUM = 8;

    typedef struct packed {
        logic [2:0]        stat;
        logic [NIBBLE-1:0] icode;
        logic [NIBBLE-1:0] ifun;
        logic [NIBBLE-1:0] ra;
        logic [NIBBLE-1:0] rb;
        logic [WORD-1:0]   valc;
        logic [WORD-1:0]   valp;
    } d_reg_t;

    function automatic d_reg_t d_bubble_value();
        d_reg_t v;
        v.stat  = S_BUB;
        v.icode = I_NOP;
        v.ifun  = 4'h0;
        v.ra    = RNONE;
        v.rb    = RNONE;
        v.valc  = '0;
        v.valp  = '0;
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_fwd_sel.sv
// Five-source operand select: execute, memory (load then ALU), write-back (load then ALU), else
// register file. A source of RNONE never matches and yields zero.
module fwd_sel
    import decode_stage_pkg::*;
(
    input  logic [3:0]  src,
    input  logic [3:0]  e_dste,
    input  logic [31:0] e_vale,
    input  logic [3:0]  m_dstm,
    input  logic [31:0] m_valm,
    input  logic [3:0]  m_dste,
    input  logic [31:0] m_vale,
    input  logic [3:0]  w_dstm,
    input  logic [31:0] w_valm,
    input  logic [3:0]  w_dste,
    input  logic [31:0] w_vale,
    input  logic [31:0] rval,
    output logic [31:0] val
);

    always_comb begin
        val = '0;
        if (src != RNONE) begin
            // Youngest producer wins: it holds the most recent value of the register.
            if (src == e_dste)      val = e_vale;
            else if (src == m_dstm) val = m_valm;
            else if (src == m_dste) val = m_vale;
            else if (src == w_dstm) val = w_valm;
            else if (src == w_dste) val = w_vale;
            else                    val = rval;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: D register, register-ID decode and operand resolution.
// Forwarding is built only when FORWARD_EN is defined; otherwise operands come straight from the register file.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [3:0] RSP_ID = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  f_stat,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [31:0] f_valC,
    input  logic [31:0] f_valP,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [31:0] rvalA,
    input  logic [31:0] rvalB,
    input  logic [3:0]  e_dstE,
    input  logic [31:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [31:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [31:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [31:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [31:0] W_valM,
    output logic [2:0]  d_stat,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [31:0] d_valC,
    output logic [31:0] d_valA,
    output logic [31:0] d_valB
);

    d_reg_t d_q;
    d_reg_t d_d;

    // Stall outranks bubble so a stalled instruction is never lost.
    always_comb begin
        d_d = d_q;
        if (D_stall) begin
            d_d = d_q;
        end else if (D_bubble) begin
            d_d = d_bubble_value();
        end else begin
            d_d.stat  = f_stat;
            d_d.icode = f_icode;
            d_d.ifun  = f_ifun;
            d_d.ra    = f_rA;
            d_d.rb    = f_rB;
            d_d.valc  = f_valC;
            d_d.valp  = f_valP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= d_bubble_value();
        end else begin
            d_q <= d_d;
        end
    end

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (d_q.icode)
            I_RRMOVL: begin
                srcA = d_q.ra;
                dstE = d_q.rb;
            end
            I_IRMOVL: dstE = d_q.rb;
            I_RMMOVL: begin
                srcA = d_q.ra;
                srcB = d_q.rb;
            end
            I_MRMOVL: begin
                srcB = d_q.rb;
                dstM = d_q.ra;
            end
            I_OPL: begin
                srcA = d_q.ra;
                srcB = d_q.rb;
                dstE = d_q.rb;
            end
            I_PUSHL: begin
                srcA = d_q.ra;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_POPL: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = d_q.ra;
            end
            I_CALL: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_RET: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            default: ;
        endcase
    end

    logic [3:0] e_dste_sel;
    logic [3:0] m_dstm_sel;
    logic [3:0] m_dste_sel;
    logic [3:0] w_dstm_sel;
    logic [3:0] w_dste_sel;

`ifdef FORWARD_EN
    assign e_dste_sel = e_dstE;
    assign m_dstm_sel = M_dstM;
    assign m_dste_sel = M_dstE;
    assign w_dstm_sel = W_dstM;
    assign w_dste_sel = W_dstE;
`else
    // Hazard unit stalls instead; tying every producer to RNONE turns the selects into plain register reads.
    logic unused_fwd_ids;
    assign unused_fwd_ids = ^{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    assign e_dste_sel = RNONE;
    assign m_dstm_sel = RNONE;
    assign m_dste_sel = RNONE;
    assign w_dstm_sel = RNONE;
    assign w_dste_sel = RNONE;
`endif

    logic [31:0] val_a_sel;
    logic [31:0] val_b_sel;

    fwd_sel u_fwd_a (
        .src    (srcA),
        .e_dste (e_dste_sel),
        .e_vale (e_valE),
        .m_dstm (m_dstm_sel),
        .m_valm (m_valM),
        .m_dste (m_dste_sel),
        .m_vale (M_valE),
        .w_dstm (w_dstm_sel),
        .w_valm (W_valM),
        .w_dste (w_dste_sel),
        .w_vale (W_valE),
        .rval   (rvalA),
        .val    (val_a_sel)
    );

    fwd_sel u_fwd_b (
        .src    (srcB),
        .e_dste (e_dste_sel),
        .e_vale (e_valE),
        .m_dstm (m_dstm_sel),
        .m_valm (m_valM),
        .m_dste (m_dste_sel),
        .m_vale (M_valE),
        .w_dstm (w_dstm_sel),
        .w_valm (W_valM),
        .w_dste (w_dste_sel),
        .w_vale (W_valE),
        .rval   (rvalB),
        .val    (val_b_sel)
    );

    // CALL and JXX carry the return/fall-through address in valA instead of a register.
    assign d_valA = (d_q.icode == I_CALL || d_q.icode == I_JXX) ? d_q.valp : val_a_sel;
    assign d_valB = val_b_sel;

    assign d_stat  = d_q.stat;
    assign d_icode = d_q.icode;
    assign d_ifun  = d_q.ifun;
    assign d_valC  = d_q.valc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a table-driven model of the decode rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [31:0] f_valC, f_valP;
    logic        D_stall, D_bubble;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [31:0] rvalA, rvalB;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [31:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode, d_ifun;
    logic [31:0] d_valC, d_valA, d_valB;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .rvalA(rvalA), .rvalB(rvalB),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_valA(d_valA), .d_valB(d_valB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the D register contents as plain variables.
    logic [2:0]  m_stat;
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
    logic [31:0] m_valc, m_valp;

    always @(posedge clk) begin
        if (rst || (!D_stall && D_bubble)) begin
            m_stat = 3'd0; m_icode = 4'h1; m_ifun = 4'h0;
            m_ra = 4'hF; m_rb = 4'hF; m_valc = 0; m_valp = 0;
        end else if (!D_stall) begin
            m_stat = f_stat; m_icode = f_icode; m_ifun = f_ifun;
            m_ra = f_rA; m_rb = f_rB; m_valc = f_valC; m_valp = f_valP;
        end
    end

    // Decode tables: 'A' = rA, 'B' = rB, 'S' = stack pointer, '-' = none.
    function automatic logic [3:0] pick(input byte code, input logic [3:0] ra, input logic [3:0] rb);
        case (code)
            "A": return ra;
            "B": return rb;
            "S": return 4'h4;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] exp_id(input int which, input logic [3:0] ic,
                                          input logic [3:0] ra, input logic [3:0] rb);
        string tbl_srca, tbl_srcb, tbl_dste, tbl_dstm;
        string t;
        //          icode: 0123456789AB
        tbl_srca = "--A-A-A--SAS";
        tbl_srcb = "----BBB-SSSS";
        tbl_dste = "--BB--B-SSSS";
        tbl_dstm = "-----A-----A";
        t = (which == 0) ? tbl_srca : (which == 1) ? tbl_srcb : (which == 2) ? tbl_dste : tbl_dstm;
        if (ic > 4'hB) return 4'hF;
        return pick(t[ic], ra, rb);
    endfunction

    function automatic logic [31:0] exp_operand(input logic [3:0] src, input logic [31:0] rval);
        logic [3:0]  ids [5];
        logic [31:0] vals[5];
        if (src == 4'hF) return 32'h0;
`ifdef FORWARD_EN
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        for (int i = 0; i < 5; i++)
            if (ids[i] == src) return vals[i];
`else
        ids  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        if (ids[0] == src) return vals[0];
`endif
        return rval;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [3:0] ea, eb;
            ea = exp_id(0, m_icode, m_ra, m_rb);
            eb = exp_id(1, m_icode, m_ra, m_rb);
            chk("m_srcA", srcA, ea);
            chk("m_srcB", srcB, eb);
            chk("m_dstE", dstE, exp_id(2, m_icode, m_ra, m_rb));
            chk("m_dstM", dstM, exp_id(3, m_icode, m_ra, m_rb));
            chk("m_stat", d_stat, m_stat);
            chk("m_icode", d_icode, m_icode);
            chk("m_ifun", d_ifun, m_ifun);
            chk("m_valC", d_valC, m_valc);
            chk("m_valA", d_valA, (m_icode == 4'h8 || m_icode == 4'h7) ? m_valp : exp_operand(ea, rvalA));
            chk("m_valB", d_valB, exp_operand(eb, rvalB));
        end
    end

    task automatic quiet();
        rst = 0; D_stall = 0; D_bubble = 0;
        f_stat = 3'd1; f_icode = 4'h1; f_ifun = 0; f_rA = 4'hF; f_rB = 4'hF;
        f_valC = 0; f_valP = 0; rvalA = 0; rvalB = 0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        f_icode = ic; f_rA = ra; f_rB = rb;
    endtask

    function automatic logic [3:0] rnd_id();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    initial begin
        quiet();
        rst = 1;
        step();
        check_en = 1'b1;
        chk("rst_srcA", srcA, 4'hF);
        chk("rst_dstM", dstM, 4'hF);
        chk("rst_icode", d_icode, 4'h1);
        chk("rst_stat", d_stat, 3'd0);
        chk("rst_valA", d_valA, 32'h0);
        chk("rst_valB", d_valB, 32'h0);

        // OPL r1, r2 with no forwarding hit
        quiet(); load(4'h6, 4'h1, 4'h2); rvalA = 5; rvalB = 7;
        step();
        chk("opl_srcA", srcA, 4'h1);
        chk("opl_srcB", srcB, 4'h2);
        chk("opl_dstE", dstE, 4'h2);
        chk("opl_dstM", dstM, 4'hF);
        chk("opl_valA", d_valA, 32'd5);
        chk("opl_valB", d_valB, 32'd7);

        // Execute and write-back both target r1
        e_dstE = 4'h1; e_valE = 99; W_dstE = 4'h1; W_valE = 11;
        step();
`ifdef FORWARD_EN
        chk("fwd_e_over_w", d_valA, 32'd99);
`else
        chk("nofwd_valA", d_valA, 32'd5);
`endif

        // CALL uses valP as valA and the stack pointer for srcB/dstE
        quiet(); load(4'h8, 4'hF, 4'hF); f_valP = 32'h40; rvalB = 32'h77;
        step();
        chk("call_srcB", srcB, 4'h4);
        chk("call_dstE", dstE, 4'h4);
        chk("call_valA", d_valA, 32'h40);
        chk("call_valB", d_valB, 32'h77);

        // Stall holds through new fetch data, also when bubble asserted together
        quiet(); load(4'h6, 4'h1, 4'h2); f_valC = 32'h1234;
        step();
        load(4'h3, 4'h5, 4'h6); f_valC = 32'hDEAD; D_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_srcA", srcA, 4'h1);
            chk("stall_valC", d_valC, 32'h1234);
        end
        D_bubble = 1;
        step();
        chk("stall_bub_icode", d_icode, 4'h6);
        D_stall = 0;
        step();
        chk("bub_icode", d_icode, 4'h1);
        chk("bub_stat", d_stat, 3'd0);
        chk("bub_srcA", srcA, 4'hF);

        // POPL r3 with memory-stage load and ALU both targeting %esp
        quiet(); load(4'hB, 4'h3, 4'hF); rvalA = 5; rvalB = 7;
        M_dstM = 4'h4; m_valM = 32'h100; M_dstE = 4'h4; M_valE = 32'h200;
        step();
        chk("pop_srcA", srcA, 4'h4);
        chk("pop_srcB", srcB, 4'h4);
        chk("pop_dstE", dstE, 4'h4);
        chk("pop_dstM", dstM, 4'h3);
`ifdef FORWARD_EN
        chk("pop_valA", d_valA, 32'h100);
        chk("pop_valB", d_valB, 32'h100);
`else
        chk("pop_valA", d_valA, 32'd5);
        chk("pop_valB", d_valB, 32'd7);
`endif

        // Randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            D_stall  = ($urandom_range(0, 6) == 0);
            D_bubble = ($urandom_range(0, 6) == 0);
            f_stat   = 3'($urandom_range(0, 4));
            f_icode  = 4'($urandom_range(0, 15));
            f_ifun   = 4'($urandom_range(0, 15));
            f_rA     = rnd_id();
            f_rB     = rnd_id();
            f_valC   = $urandom;
            f_valP   = $urandom;
            rvalA    = $urandom;
            rvalB    = $urandom;
            e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
            W_dstE = rnd_id(); W_dstM = rnd_id();
            e_valE = $urandom; M_valE = $urandom; m_valM = $urandom;
            W_valE = $urandom; W_valM = $urandom;
            step();
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
